// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic a_signed(input mdu_op_e op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic b_signed(input mdu_op_e op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module mdu_div_step #(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0] rem_i,
  input  logic [DataWidth-1:0] quo_i,
  input  logic [DataWidth-1:0] divisor_i,
  output logic [DataWidth-1:0] rem_o,
  output logic [DataWidth-1:0] quo_o
);
  localparam int unsigned W = DataWidth;

  logic [W:0] rem_sh;
  logic [W:0] diff;
  logic       fits;

  assign rem_sh = {rem_i, quo_i[W-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};
  // rem_sh < 2*divisor, so the top bit of the difference is a clean borrow flag
  assign fits   = ~diff[W];
  assign rem_o  = fits ? diff[W-1:0] : rem_sh[W-1:0];
  assign quo_o  = {quo_i[W-2:0], fits};

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Define MDU_FAST_MUL_EN to resolve the multiply ops combinationally at accept.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           op_i,
  input  logic [DataWidth-1:0] src_a_i,
  input  logic [DataWidth-1:0] src_b_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 busy_o
);
  localparam int unsigned W    = DataWidth;
  localparam int unsigned CntW = $clog2(DataWidth) + 1;
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  logic [2*W-1:0]  acc_q, acc_d;     // product for mul, {remainder, quotient} for div
  logic [W-1:0]    opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [W-1:0]    result_q, result_d;
  logic            neg_q, neg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  mdu_op_e        op_in;
  logic           a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]   a_mag, b_mag;

  assign op_in    = mdu_op_e'(op_i);
  assign a_neg    = a_signed(op_in) & src_a_i[W-1];
  assign b_neg    = b_signed(op_in) & src_b_i[W-1];
  assign a_mag    = a_neg ? -src_a_i : src_a_i;
  assign b_mag    = b_neg ? -src_b_i : src_b_i;
  assign div_zero = is_div(op_in) && (src_b_i == '0);
  assign div_ovf  = is_div(op_in) && a_signed(op_in) && (src_a_i == MinNeg) && (src_b_i == '1);

`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{a_neg}}, src_a_i} * {{W{b_neg}}, src_b_i};
`endif

  logic [W-1:0]   addend, div_rem, div_quo, quo_fix, rem_fix, final_res;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt, prod_fix;

  assign addend  = acc_q[0] ? opnd_q : '0;
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
  assign mul_nxt = {mul_sum, acc_q[W-1:1]};

  mdu_div_step #(
    .DataWidth(W)
  ) u_div_step (
    .rem_i    (acc_q[2*W-1:W]),
    .quo_i    (acc_q[W-1:0]),
    .divisor_i(opnd_q),
    .rem_o    (div_rem),
    .quo_o    (div_quo)
  );

  assign prod_fix  = neg_q ? -mul_nxt : mul_nxt;
  assign quo_fix   = neg_q ? -div_quo : div_quo;
  assign rem_fix   = neg_q ? -div_rem : div_rem;
  assign final_res = is_div(op_q) ? (is_rem(op_q) ? rem_fix : quo_fix)
                                  : ((op_q == OpMul) ? prod_fix[W-1:0] : prod_fix[2*W-1:W]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i && !flush_i) begin
          op_d    = op_in;
          neg_d   = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
          cnt_d   = CntW'(W);
          state_d = StBusy;
          if (is_div(op_in)) begin
            acc_d  = {{W{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{W{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          if (div_zero) begin
            result_d = is_rem(op_in) ? src_a_i : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = is_rem(op_in) ? '0 : src_a_i;
            state_d  = StDone;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!is_div(op_in)) begin
            result_d = (op_in == OpMul) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
            state_d  = StDone;
          end
`endif
        end
      end
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div(op_q) ? {div_rem, div_quo} : mul_nxt;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            result_d = final_res;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (flush_i || out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;

endmodule
